truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer.sv | 95 +++++++++
 tb/tb_truth_table_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// Drives a 2-input gate under test through all four input vectors, holding each
// for HOLD cycles, and counts samples of y_in that disagree with TRUTH.
module truth_table_sequencer #(
    parameter int         HOLD  = 10,
    parameter logic [3:0] TRUTH = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state;
    logic [7:0] cnt;
    logic       last;
    logic       mism;
    logic [1:0] nxt_idx;
    logic [2:0] err_upd;

    assign last    = (cnt == 8'(HOLD - 1));
    assign nxt_idx = vec_idx + 2'd1;
    // Case inequality so an undriven or X gate output is scored as a mismatch
    assign mism    = (y_in !== TRUTH[vec_idx]);
    assign err_upd = (mism && err_count < 3'd4) ? err_count + 3'd1 : err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            vec_idx   <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            err_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // abort is deliberately not looked at outside RUN
                    if (start) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        vec_idx   <= '0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        err_count <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Partial count is kept; any compare on this edge is dropped
                        state   <= S_IDLE;
                        cnt     <= '0;
                        vec_idx <= '0;
                        a       <= 1'b0;
                        b       <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else if (last) begin
                        err_count <= err_upd;
                        cnt       <= '0;
                        if (vec_idx == 2'd3) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_upd == 3'd0);
                        end else begin
                            vec_idx <= nxt_idx;
                            a       <= nxt_idx[1];
                            b       <= nxt_idx[0];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Two sequencers (AND and OR truth tables) share stimulus; a per-cycle reference
// derived from cycle position and gate behaviour scores both.
module tb_truth_table_sequencer;
    localparam int         HOLD = 10;
    localparam logic [3:0] T1   = 4'b1000;
    localparam logic [3:0] T2   = 4'b1110;

    logic clk = 1'b0;
    logic rst, start, abort, ry;
    int   mode;
    int   passed = 0;
    int   total  = 0;

    logic       y1, a1, b1, busy1, done1, pass1;
    logic [1:0] v1;
    logic [2:0] e1;
    logic       y2, a2, b2, busy2, done2, pass2;
    logic [1:0] v2;
    logic [2:0] e2;

    always #5 clk = ~clk;

    // mode 0 AND, 1 OR, 2 stuck-at-1, 3 random per cycle
    function automatic logic gate(input int m, input logic [1:0] i, input logic r);
        case (m)
            0:       return (i == 2'd3);
            1:       return (i != 2'd0);
            2:       return 1'b1;
            default: return r;
        endcase
    endfunction

    assign y1 = gate(mode, {a1, b1}, ry);
    assign y2 = gate(mode, {a2, b2}, ry);

    truth_table_sequencer #(.HOLD(HOLD), .TRUTH(T1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y1),
        .a(a1), .b(b1), .vec_idx(v1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(e1)
    );

    truth_table_sequencer #(.HOLD(HOLD), .TRUTH(T2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y2),
        .a(a2), .b(b2), .vec_idx(v2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(e2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Starts a sweep and follows it cycle by cycle against the reference.
    // abort_edge: edge number after start at which abort is sampled (-1 none).
    // start_pulse: cycle at which a stray start is raised during RUN (-1 none).
    task automatic run_sweep(input int m, input bit hold_start, input int abort_edge,
                             input int start_pulse, output int r1, output int r2);
        int         err1 = 0;
        int         err2 = 0;
        bit         aborted = 0;
        logic [1:0] iv;
        logic [9:0] exp1, exp2, got1, got2;
        mode  = m;
        start = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        for (int j = 0; j < 4 * HOLD; j++) begin
            iv   = 2'(j / HOLD);
            exp1 = {1'b1, 1'b0, 1'b0, iv, iv, 3'(err1)};
            exp2 = {1'b1, 1'b0, 1'b0, iv, iv, 3'(err2)};
            got1 = {busy1, done1, pass1, a1, b1, v1, e1};
            got2 = {busy2, done2, pass2, a2, b2, v2, e2};
            total++;
            if (got1 !== exp1) $display("FAIL run1 j=%0d got %h want %h", j, got1, exp1);
            else passed++;
            total++;
            if (got2 !== exp2) $display("FAIL run2 j=%0d got %h want %h", j, got2, exp2);
            else passed++;
            ry = 1'($urandom);
            if (j == start_pulse) start = 1'b1;
            else if (!hold_start) start = 1'b0;
            if (j + 1 == abort_edge) abort = 1'b1;
            if ((j + 1) % HOLD == 0 && j + 1 != abort_edge) begin
                err1 += int'(gate(m, iv, ry) !== T1[iv]);
                err2 += int'(gate(m, iv, ry) !== T2[iv]);
            end
            step();
            abort = 1'b0;
            if (j + 1 == abort_edge) begin
                aborted = 1;
                break;
            end
        end
        if (!hold_start) start = 1'b0;
        if (aborted) begin
            exp1 = {7'b0, 3'(err1)};
            exp2 = {7'b0, 3'(err2)};
        end else begin
            exp1 = {1'b0, 1'b1, err1 == 0, 2'b11, 2'b11, 3'(err1)};
            exp2 = {1'b0, 1'b1, err2 == 0, 2'b11, 2'b11, 3'(err2)};
        end
        got1 = {busy1, done1, pass1, a1, b1, v1, e1};
        got2 = {busy2, done2, pass2, a2, b2, v2, e2};
        total++;
        if (got1 !== exp1) $display("FAIL end1 got %h want %h", got1, exp1);
        else passed++;
        total++;
        if (got2 !== exp2) $display("FAIL end2 got %h want %h", got2, exp2);
        else passed++;
        r1 = err1;
        r2 = err2;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ry = 1'b0; mode = 0;
        repeat (3) step();
        total++;
        if ({a1, b1, v1, busy1, done1, pass1, e1} !== 10'd0)
            $display("FAIL reset1 got %h want 0", {a1, b1, v1, busy1, done1, pass1, e1});
        else passed++;
        #2 rst = 1'b0;
        start = 1'b0;
        repeat (3) step();
        total++;
        if ({busy2, done2, e2} !== 5'd0) $display("FAIL reset_idle got %h want 0", {busy2, done2, e2});
        else passed++;
    endtask

    task automatic test_and_gate;
        int r1, r2;
        run_sweep(0, 0, -1, -1, r1, r2);
        total++;
        if ({done1, pass1, e1} !== {2'b11, 3'd0}) $display("FAIL and_t1000 got %h want 18", {done1, pass1, e1});
        else passed++;
        total++;
        if ({done2, pass2, e2} !== {2'b10, 3'd2}) $display("FAIL and_t1110 got %h want 12", {done2, pass2, e2});
        else passed++;
    endtask

    task automatic test_stuck_one;
        int r1, r2;
        run_sweep(2, 0, -1, 7, r1, r2);
        total++;
        if ({done1, pass1, e1} !== {2'b10, 3'd3}) $display("FAIL stuck1 got %h want 13", {done1, pass1, e1});
        else passed++;
        total++;
        if (e2 !== 3'd1) $display("FAIL stuck1_t1110 got %0d want 1", e2);
        else passed++;
    endtask

    task automatic test_or_gate;
        int r1, r2;
        run_sweep(1, 0, -1, -1, r1, r2);
        total++;
        if ({done2, pass2, e2} !== {2'b11, 3'd0}) $display("FAIL or_t1110 got %h want 18", {done2, pass2, e2});
        else passed++;
        total++;
        if (e1 !== 3'd2) $display("FAIL or_t1000 got %0d want 2", e1);
        else passed++;
    endtask

    task automatic test_abort;
        int r1, r2;
        run_sweep(2, 0, 15, -1, r1, r2);
        total++;
        if (e1 !== 3'd1) $display("FAIL abort15 err got %0d want 1", e1);
        else passed++;
        abort = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            total++;
            if ({busy1, done1, a1, b1, e1} !== {4'b0, 3'd1})
                $display("FAIL abort_idle k=%0d got %h want 1", k, {busy1, done1, a1, b1, e1});
            else passed++;
        end
        abort = 1'b0;
        // abort exactly on the compare edge drops that compare
        run_sweep(2, 0, 20, -1, r1, r2);
        total++;
        if (e1 !== 3'd1) $display("FAIL abort20 err got %0d want 1", e1);
        else passed++;
        run_sweep(0, 0, -1, -1, r1, r2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if ({done1, pass1, busy1, v1} !== {3'b110, 2'd3}) $display("FAIL abort_in_done got %h want 1b", {done1, pass1, busy1, v1});
        else passed++;
    endtask

    task automatic test_async_reset;
        int r1, r2;
        mode  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (17) step();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({a1, b1, v1, busy1, done1, pass1, e1} !== 10'd0)
            $display("FAIL async_rst got %h want 0", {a1, b1, v1, busy1, done1, pass1, e1});
        else passed++;
        step();
        #3 rst = 1'b0;
        for (int k = 0; k < 45; k++) begin
            step();
            total++;
            if ({busy1, done1, v1} !== 4'd0) $display("FAIL post_rst k=%0d got %h want 0", k, {busy1, done1, v1});
            else passed++;
        end
        run_sweep(0, 0, -1, -1, r1, r2);
        total++;
        if (pass1 !== 1'b1) $display("FAIL post_rst_sweep pass got %b want 1", pass1);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int r1, r2;
        run_sweep(2, 1, -1, -1, r1, r2);
        run_sweep(0, 1, -1, -1, r1, r2);
        total++;
        if ({pass1, e1} !== {1'b1, 3'd0}) $display("FAIL b2b_clear got %h want 8", {pass1, e1});
        else passed++;
        run_sweep(2, 1, -1, -1, r1, r2);
        start = 1'b0;
        step();
        total++;
        if ({done1, busy1, e1} !== {2'b10, 3'd3}) $display("FAIL b2b_hold got %h want 13", {done1, busy1, e1});
        else passed++;
    endtask

    task automatic test_random;
        int r1, r2, ab, sp;
        for (int n = 0; n < 8; n++) begin
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4 * HOLD - 1)) : -1;
            sp = int'($urandom_range(0, 4 * HOLD - 1));
            run_sweep(3, 0, ab, sp, r1, r2);
            total++;
            if (e1 !== 3'(r1) || e2 !== 3'(r2))
                $display("FAIL rand n=%0d got %0d/%0d want %0d/%0d", n, e1, e2, r1, r2);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_and_gate();
        test_stuck_one();
        test_or_gate();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
